// File: rtl/bist_controller.sv
// BIST sequencer: seeds the pattern generator, runs NPAT patterns, flushes the
// CUT pipeline into the MISR, then compares the signature against GOLDEN.
module bist_controller #(
  parameter int                NPAT   = 255,
  parameter int                CNT_W  = 8,
  parameter int                LAT    = 1,
  parameter int                SIG_W  = 3,
  parameter logic [SIG_W-1:0]  GOLDEN = 3'b101
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [SIG_W-1:0] SIG,
  output logic             TEST_MODE,
  output logic             TPG_LOAD,
  output logic             TPG_EN,
  output logic             MISR_CLR,
  output logic             MISR_EN,
  output logic [CNT_W-1:0] PAT_CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL
);

  // A pattern counter that could wrap, or a latency the flush counter cannot hold, is a build error.
  if (NPAT < 1 || NPAT > (2**CNT_W) - 1) begin : g_bad_npat
    $error("bist_controller: NPAT out of range for CNT_W");
  end
  if (LAT < 0 || LAT > 15) begin : g_bad_lat
    $error("bist_controller: LAT out of range 0..15");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] LAST_PAT   = CNT_W'(NPAT - 1);
  localparam logic [3:0]       LAST_FLUSH = 4'(LAT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] pat_cnt;
  logic [3:0]       flush_cnt;
  logic             pass_q;
  logic             fail_q;

  // START only acts from IDLE/DONE; ABORT only from the busy states and wins over START there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      pat_cnt   <= '0;
      flush_cnt <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state   <= S_INIT;
            pat_cnt <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
          end
        end
        default: begin
          if (ABORT) begin
            state   <= S_IDLE;
            pat_cnt <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
          end else begin
            case (state)
              S_INIT: state <= S_RUN;
              S_RUN: begin
                pat_cnt <= pat_cnt + 1'b1;
                if (pat_cnt == LAST_PAT) begin
                  flush_cnt <= '0;
                  state     <= (LAT == 0) ? S_CMP : S_FLUSH;
                end
              end
              S_FLUSH: begin
                flush_cnt <= flush_cnt + 1'b1;
                if (flush_cnt == LAST_FLUSH) state <= S_CMP;
              end
              S_CMP: begin
                pass_q <= (SIG == GOLDEN);
                fail_q <= (SIG != GOLDEN);
                state  <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Control strobes are pure state decodes so they are glitch-free relative to the state register.
  assign TEST_MODE = (state == S_INIT) || (state == S_RUN) || (state == S_FLUSH) || (state == S_CMP);
  assign TPG_LOAD  = (state == S_INIT);
  assign MISR_CLR  = (state == S_INIT);
  assign TPG_EN    = (state == S_RUN);
  assign MISR_EN   = (state == S_RUN) || (state == S_FLUSH);
  assign BUSY      = TEST_MODE;
  assign DONE      = (state == S_DONE);
  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign PAT_CNT   = pat_cnt;

endmodule
